// File: rtl/cmp_sticky_pkg.sv
// cmp_sticky_pkg: relation codes and channel FSM encoding for the sticky comparator
package cmp_sticky_pkg;
  localparam logic [1:0] MODE_EQ = 2'b00;
  localparam logic [1:0] MODE_NE = 2'b01;
  localparam logic [1:0] MODE_GT = 2'b10;
  localparam logic [1:0] MODE_LT = 2'b11;
  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_COUNT   = 2'b01,
    ST_LATCHED = 2'b10
  } state_e;
endpackage

// File: rtl/cmp_sticky_channel.sv
// cmp_sticky_channel: one comparator lane with HOLD-cycle qualification and a sticky hit flag
module cmp_sticky_channel
  import cmp_sticky_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int HOLD  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       mode,
  input  logic             en,
  input  logic             clr,
  output logic             live,
  output logic             hit,
  output logic             rise
);
  localparam int CW = $clog2(HOLD + 1);
  state_e        st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic          cond, live_q, hit_q, hit_d;
  assign cond = (mode == MODE_EQ) ? (a == b) :
                (mode == MODE_NE) ? (a != b) :
                (mode == MODE_GT) ? (a > b)  : (a < b);
  assign cnt_inc = cnt_q + CW'(1);
  // Disabled cycles in COUNT fall through the chain untouched, freezing the run.
  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    if (clr) begin
      st_d  = ST_IDLE;
      cnt_d = '0;
    end else if (st_q == ST_IDLE) begin
      st_d  = (en && cond) ? ((HOLD == 1) ? ST_LATCHED : ST_COUNT) : ST_IDLE;
      cnt_d = (en && cond) ? CW'(1) : '0;
    end else if (st_q == ST_COUNT && en) begin
      st_d  = !cond ? ST_IDLE : (cnt_inc == CW'(HOLD)) ? ST_LATCHED : ST_COUNT;
      cnt_d = cond ? cnt_inc : '0;
    end
  end
  assign hit_d = (st_d == ST_LATCHED);
  assign rise  = hit_d & ~hit_q;
  assign live  = live_q;
  assign hit   = hit_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q   <= ST_IDLE;
      cnt_q  <= '0;
      hit_q  <= 1'b0;
      live_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      hit_q  <= hit_d;
      live_q <= cond;
    end
  end
endmodule

// File: rtl/cmp_sticky_detector.sv
// cmp_sticky_detector: multi-channel qualified comparator with sticky hits and first-hit capture
module cmp_sticky_detector
  import cmp_sticky_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int HOLD     = 3
) (
  input  logic                                             clk,
  input  logic                                             rst,
  input  logic [CHANNELS*WIDTH-1:0]                        a,
  input  logic [CHANNELS*WIDTH-1:0]                        b,
  input  logic [1:0]                                       mode,
  input  logic                                             en,
  input  logic                                             clr,
  output logic [CHANNELS-1:0]                              live,
  output logic [CHANNELS-1:0]                              hit,
  output logic                                             any_hit,
  output logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] first_ch,
  output logic                                             first_valid
);
  localparam int IW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  logic [CHANNELS-1:0] rise;
  logic [IW-1:0]       first_ch_q, rise_idx;
  logic                first_valid_q, any_hit_q;
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    cmp_sticky_channel #(.WIDTH(WIDTH), .HOLD(HOLD)) u_ch (
      .clk  (clk),
      .rst  (rst),
      .a    (a[i*WIDTH +: WIDTH]),
      .b    (b[i*WIDTH +: WIDTH]),
      .mode (mode),
      .en   (en),
      .clr  (clr),
      .live (live[i]),
      .hit  (hit[i]),
      .rise (rise[i])
    );
  end
  // Scan high to low so the lowest rising index wins.
  always_comb begin
    rise_idx = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) if (rise[i]) rise_idx = IW'(i);
  end
  assign any_hit     = any_hit_q;
  assign first_ch    = first_ch_q;
  assign first_valid = first_valid_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      any_hit_q     <= 1'b0;
      first_ch_q    <= '0;
      first_valid_q <= 1'b0;
    end else begin
      any_hit_q <= |hit;
      if (clr) begin
        first_ch_q    <= '0;
        first_valid_q <= 1'b0;
      end else if (!first_valid_q && |rise) begin
        first_ch_q    <= rise_idx;
        first_valid_q <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_cmp_sticky_detector.sv
// tb_cmp_sticky_detector: directed scenarios plus randomized run against a run-length reference model
module tb_cmp_sticky_detector;
  localparam int W = 8, N = 4, H = 3;
  logic clk = 0, rst = 0, en = 0, clr = 0;
  logic [N*W-1:0] a = '0, b = '0;
  logic [1:0] mode = 2'b00;
  logic [N-1:0] live, hit;
  logic any_hit, first_valid;
  logic [1:0] first_ch;
  int total = 0, bad = 0;
  int run_m [N];
  logic [N-1:0] hit_m, live_m;
  logic any_m, fv_m;
  logic [1:0] fc_m;

  cmp_sticky_detector #(.WIDTH(W), .CHANNELS(N), .HOLD(H)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .mode(mode), .en(en), .clr(clr),
    .live(live), .hit(hit), .any_hit(any_hit), .first_ch(first_ch), .first_valid(first_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pk(input logic [7:0] c3, c2, c1, c0);
    return {c3, c2, c1, c0};
  endfunction

  function automatic logic rel(input logic [7:0] x, y, input logic [1:0] m);
    int ux = int'(x), uy = int'(y);
    case (m)
      2'b00: return ux == uy;
      2'b01: return ux != uy;
      2'b10: return ux > uy;
      default: return ux < uy;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) run_m[i] = 0;
    hit_m = '0; live_m = '0; any_m = 0; fv_m = 0; fc_m = '0;
  endtask

  // Drive one cycle's inputs, clock it, advance the model, settle 1 time unit past the edge.
  task automatic tick(input logic [31:0] av, bv, input logic [1:0] m, input logic e, c);
    logic [N-1:0] old;
    a = av; b = bv; mode = m; en = e; clr = c;
    @(posedge clk);
    old = hit_m;
    any_m = |hit_m;
    for (int i = 0; i < N; i++) live_m[i] = rel(av[i*W +: W], bv[i*W +: W], m);
    if (c) begin
      for (int i = 0; i < N; i++) run_m[i] = 0;
      hit_m = '0; fv_m = 0; fc_m = '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (e) run_m[i] = live_m[i] ? run_m[i] + 1 : 0;
        if (run_m[i] >= H) hit_m[i] = 1'b1;
      end
      if (!fv_m && |(hit_m & ~old)) begin
        fv_m = 1'b1;
        for (int i = N - 1; i >= 0; i--) if (hit_m[i] && !old[i]) fc_m = 2'(i);
      end
    end
    #1;
  endtask

  task automatic test_reset();
    a = $urandom; b = $urandom; mode = 2'($urandom); en = 1; clr = 0;
    #1 rst = 1;
    #1;
    total++; if (live !== 4'b0) begin bad++; $display("FAIL reset_live got=%b exp=0000", live); end
    total++; if (hit !== 4'b0) begin bad++; $display("FAIL reset_hit got=%b exp=0000", hit); end
    total++; if (any_hit !== 1'b0) begin bad++; $display("FAIL reset_any got=%b exp=0", any_hit); end
    total++; if (first_ch !== 2'd0) begin bad++; $display("FAIL reset_fc got=%0d exp=0", first_ch); end
    total++; if (first_valid !== 1'b0) begin bad++; $display("FAIL reset_fv got=%b exp=0", first_valid); end
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 0;
    model_reset();
  endtask

  task automatic test_equality();
    logic [31:0] av = pk(8'h03, 8'h02, 8'h01, 8'h5A), bv = pk(8'h00, 8'h00, 8'h00, 8'h5A);
    tick('0, '1, 2'b00, 0, 1);
    repeat (2) tick(av, bv, 2'b00, 1, 0);
    total++; if (hit !== 4'b0000) begin bad++; $display("FAIL eq_early got=%b exp=0000", hit); end
    tick(av, bv, 2'b00, 1, 0);
    total++; if (hit !== 4'b0001) begin bad++; $display("FAIL eq_hit got=%b exp=0001", hit); end
    total++; if (first_ch !== 2'd0 || first_valid !== 1'b1) begin bad++; $display("FAIL eq_first got=%0d/%b exp=0/1", first_ch, first_valid); end
    total++; if (any_hit !== 1'b0) begin bad++; $display("FAIL eq_any_lag got=%b exp=0", any_hit); end
    tick(av, bv, 2'b00, 1, 0);
    total++; if (any_hit !== 1'b1) begin bad++; $display("FAIL eq_any got=%b exp=1", any_hit); end
    tick(pk(8'h03, 8'h02, 8'h01, 8'h00), bv, 2'b00, 1, 0);
    total++; if (hit[0] !== 1'b1 || live[0] !== 1'b0) begin bad++; $display("FAIL eq_sticky got hit0=%b live0=%b exp=1/0", hit[0], live[0]); end
  endtask

  task automatic test_broken_run();
    logic [31:0] bv = pk(8'h00, 8'h33, 8'h00, 8'h00);
    logic [31:0] mv = pk(8'h01, 8'h33, 8'h01, 8'h01), xv = pk(8'h01, 8'h34, 8'h01, 8'h01);
    tick('0, '1, 2'b00, 0, 1);
    tick(mv, bv, 2'b00, 1, 0); tick(mv, bv, 2'b00, 1, 0);
    tick(xv, bv, 2'b00, 1, 0);
    tick(mv, bv, 2'b00, 1, 0); tick(mv, bv, 2'b00, 1, 0);
    total++; if (hit !== 4'b0000) begin bad++; $display("FAIL broken_nohit got=%b exp=0000", hit); end
    tick(mv, bv, 2'b00, 1, 0);
    total++; if (hit !== 4'b0100) begin bad++; $display("FAIL broken_hit got=%b exp=0100", hit); end
    total++; if (first_ch !== 2'd2 || first_valid !== 1'b1) begin bad++; $display("FAIL broken_first got=%0d/%b exp=2/1", first_ch, first_valid); end
  endtask

  task automatic test_enable_freeze();
    logic [31:0] bv = pk(8'h00, 8'h00, 8'hC4, 8'h00);
    logic [31:0] mv = pk(8'h01, 8'h01, 8'hC4, 8'h01), xv = pk(8'h01, 8'h01, 8'h11, 8'h01);
    tick('0, '1, 2'b00, 0, 1);
    repeat (2) tick(mv, bv, 2'b00, 1, 0);
    repeat (5) tick(xv, bv, 2'b00, 0, 0);
    total++; if (hit !== 4'b0000) begin bad++; $display("FAIL freeze_hold got=%b exp=0000", hit); end
    tick(mv, bv, 2'b00, 1, 0);
    total++; if (hit !== 4'b0010) begin bad++; $display("FAIL freeze_hit got=%b exp=0010", hit); end
  endtask

  task automatic test_simultaneous();
    logic [31:0] bv = pk(8'h77, 8'h00, 8'h77, 8'h00);
    tick('0, '1, 2'b00, 0, 1);
    repeat (3) tick(pk(8'h77, 8'h01, 8'h77, 8'h01), bv, 2'b00, 1, 0);
    total++; if (hit !== 4'b1010) begin bad++; $display("FAIL simul_hit got=%b exp=1010", hit); end
    total++; if (first_ch !== 2'd1) begin bad++; $display("FAIL simul_first got=%0d exp=1", first_ch); end
    repeat (3) tick(pk(8'h01, 8'h01, 8'h01, 8'h00), bv, 2'b00, 1, 0);
    total++; if (hit !== 4'b1011) begin bad++; $display("FAIL simul_later got=%b exp=1011", hit); end
    total++; if (first_ch !== 2'd1 || first_valid !== 1'b1) begin bad++; $display("FAIL simul_keep got=%0d/%b exp=1/1", first_ch, first_valid); end
  endtask

  task automatic test_gt_clear();
    logic [31:0] av = pk(8'h00, 8'h00, 8'h00, 8'h80), bv = pk(8'h00, 8'h00, 8'h00, 8'h7F);
    tick('0, '1, 2'b00, 0, 1);
    repeat (3) tick(av, bv, 2'b10, 1, 0);
    total++; if (hit !== 4'b0001) begin bad++; $display("FAIL gt_unsigned got=%b exp=0001", hit); end
    tick(av, bv, 2'b10, 1, 1);
    repeat (2) tick(av, bv, 2'b10, 1, 0);
    tick(av, bv, 2'b10, 1, 1);
    total++; if (hit !== 4'b0000) begin bad++; $display("FAIL clr_prio got=%b exp=0000", hit); end
    repeat (2) tick(av, bv, 2'b10, 1, 0);
    total++; if (hit !== 4'b0000) begin bad++; $display("FAIL clr_cnt got=%b exp=0000", hit); end
    tick(av, bv, 2'b10, 1, 0);
    total++; if (hit !== 4'b0001) begin bad++; $display("FAIL clr_rehit got=%b exp=0001", hit); end
    tick(av, bv, 2'b10, 0, 1);
    repeat (2) tick(av, bv, 2'b10, 1, 0);
    #2 rst = 1;
    #1 rst = 0;
    model_reset();
    repeat (2) tick(av, bv, 2'b10, 1, 0);
    total++; if (hit !== 4'b0000) begin bad++; $display("FAIL rst_cnt got=%b exp=0000", hit); end
    tick(av, bv, 2'b10, 1, 0);
    total++; if (hit !== 4'b0001) begin bad++; $display("FAIL rst_rehit got=%b exp=0001", hit); end
  endtask

  task automatic test_random();
    logic [31:0] av, bv;
    logic [1:0] m = 2'($urandom);
    tick('0, '1, 2'b00, 0, 1);
    for (int t = 0; t < 400; t++) begin
      for (int i = 0; i < N; i++) begin
        av[i*W +: W] = 8'($urandom_range(0, 3)) + ((i == 3) ? 8'hFC : 8'h00);
        bv[i*W +: W] = 8'($urandom_range(0, 3)) + ((i == 3) ? 8'hFC : 8'h00);
      end
      if ($urandom_range(0, 9) == 0) m = 2'($urandom);
      tick(av, bv, m, $urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0);
      total++; if (live !== live_m) begin bad++; $display("FAIL rnd_live t=%0d got=%b exp=%b", t, live, live_m); end
      total++; if (hit !== hit_m) begin bad++; $display("FAIL rnd_hit t=%0d got=%b exp=%b", t, hit, hit_m); end
      total++; if (any_hit !== any_m) begin bad++; $display("FAIL rnd_any t=%0d got=%b exp=%b", t, any_hit, any_m); end
      total++; if (first_valid !== fv_m) begin bad++; $display("FAIL rnd_fv t=%0d got=%b exp=%b", t, first_valid, fv_m); end
      total++; if (first_ch !== fc_m) begin bad++; $display("FAIL rnd_fc t=%0d got=%0d exp=%0d", t, first_ch, fc_m); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_equality();
    test_broken_run();
    test_enable_freeze();
    test_simultaneous();
    test_gt_clear();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cmp_sticky_detector.md
# cmp_sticky_detector

Parametrised multi-channel comparator with per-channel qualification and sticky hit flags. Each channel compares an `a`/`b` operand pair under a selectable relation. A channel must see the relation hold for `HOLD` consecutive enabled cycles before its hit flag sets. The flag then stays set until an explicit clear. The block sits after the datapath operand registers and feeds status/interrupt logic; it replaces the old unclocked equality flag, which held its value implicitly.

## Interface
- `WIDTH`, default 8: operand width per channel, ≥1.
- `CHANNELS`, default 4: number of comparator channels, ≥1.
- `HOLD`, default 3: consecutive qualified cycles required to set a hit, ≥1.
- `clk`  in  1  — single clock, rising edge.
- `rst`  in  1  — asynchronous, active-high reset.
- `a`  in  CHANNELS*WIDTH  — operand A; channel i occupies bits [i*WIDTH +: WIDTH].
- `b`  in  CHANNELS*WIDTH  — operand B; same packing as `a`.
- `mode`  in  2  — relation shared by all channels: 00 a==b, 01 a!=b, 10 a>b unsigned, 11 a<b unsigned.
- `en`  in  1  — qualifies sampling; when low, the comparison is ignored.
- `clr`  in  1  — synchronous clear of all hit flags, counters and first-hit capture.
- `live`  out  CHANNELS  — registered raw relation result per channel.
- `hit`  out  CHANNELS  — sticky qualified-hit flag per channel.
- `any_hit`  out  1  — registered OR of `hit`.
- `first_ch`  out  max(1,$clog2(CHANNELS))  — index of the earliest channel to hit since the last clear or reset.
- `first_valid`  out  1  — `first_ch` holds a valid index.

## Operation
- Condition per channel: `cond_i` = relation(`a_i`, `b_i`, `mode`), evaluated combinationally. Comparisons are unsigned and full `WIDTH`; there is no sign extension.
- Per-channel FSM, with states IDLE, COUNT and LATCHED, and a counter of width $clog2(HOLD+1):
  - IDLE: on `en`&`cond`, go to LATCHED if `HOLD`==1; otherwise go to COUNT with cnt=1. Otherwise stay, with cnt=0.
  - COUNT on `en`&`cond`: cnt+1. If cnt+1==`HOLD`, go to LATCHED.
  - COUNT on `en`&!`cond`: go to IDLE with cnt=0. An interrupted run never partially counts.
  - COUNT on !`en`: hold state and cnt (freeze).
  - LATCHED: `hit_i`=1. Stay regardless of `en`, `cond` or `mode`.
- `clr` has priority over everything. At the clocking edge, all channels go to IDLE with cnt=0, `hit`=0, `first_valid`=0 and `first_ch`=0. The comparison in a `clr` cycle is discarded.
- `mode` change mid-COUNT does not reset counters; subsequent cycles are evaluated under the new relation.
- First-hit capture: on the first edge where any `hit` rises while `first_valid`=0, load `first_ch` with the lowest-index rising channel and set `first_valid`=1. Later hits do not change it.
- `live_i` <= `cond_i` every edge, independent of `en` and `clr`.

## Timing
- Reset (async, immediate): `live`=0, `hit`=0, `any_hit`=0, `first_ch`=0, `first_valid`=0, all FSMs IDLE, cnt=0. Reset mid-COUNT discards progress.
- `live` latency is 1 cycle.
- `hit_i` rises on the edge that samples the `HOLD`-th consecutive enabled true `cond`. Disabled cycles are not counted and do not break the run.
- `first_ch` and `first_valid` update on the same edge as the `hit` rise.
- `any_hit` lags `hit` by 1 cycle, because it is registered from the `hit` registers.
- `clr` effect is visible after the edge; `any_hit` falls one cycle later.

## Structure
- Package `cmp_sticky_pkg`:
  - mode constants `MODE_EQ`, `MODE_NE`, `MODE_GT`, `MODE_LT`;
  - FSM state encoding `ST_IDLE`, `ST_COUNT`, `ST_LATCHED`.
- Sub-module `cmp_sticky_channel`, instantiated `CHANNELS` times via generate:
  - parameters `WIDTH` and `HOLD`;
  - holds the comparator, FSM, counter, and the `live` and `hit` registers.
- Top level holds operand slicing, the `any_hit` register, and the lowest-index priority encoder with first-hit capture.

## Test plan
All scenarios use WIDTH=8, CHANNELS=4, HOLD=3.
- Reset: assert `rst` with arbitrary inputs -> all outputs 0 immediately, without waiting for a clock edge.
- Qualified equality: ch0 `a`=0x5A, `b`=0x5A, `mode`=00, `en`=1 for 3 cycles -> `hit`=0001 after the 3rd edge, `first_ch`=0, `first_valid`=1, `any_hit`=1 one cycle later. Then set `a`=0x00 -> `hit[0]` stays 1 and `live[0]`=0.
- Broken run: ch2 matches for 2 cycles, mismatches for 1, matches for 2 -> `hit[2]` never set. One further match -> `hit[2]`=1.
- Enable freeze: ch1 matches for 2 cycles, then `en`=0 for 5 cycles with mismatching operands, then 1 enabled match -> `hit[1]`=1 on that edge.
- Simultaneous hits: ch1 and ch3 reach `HOLD` on the same edge -> `first_ch`=1. A later ch0 hit leaves `first_ch`=1.
- Unsigned GT and clear priority:
  - `mode`=10, ch0 `a`=0x80, `b`=0x7F for 3 cycles -> `hit[0]`=1. This is unsigned: it would fail as signed.
  - Repeat with `clr`=1 on the 3rd cycle -> `hit[0]`=0 and the counter is zero; 3 more matches are needed to set the hit.
  - Assert `rst` mid-COUNT -> the count restarts from zero.
